// File: rtl/timer_dispatch_pkg.sv
// Shared types and constants for the timer command dispatcher.
package timer_dispatch_pkg;

  localparam int OP_W        = 4;
  localparam int CNT_W       = 24;
  localparam int OP_LONG_BIT = 3;
  localparam int REQ_W       = OP_W + CNT_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ARM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // op[OP_LONG_BIT] is interpreted by the timer; the dispatcher forwards it untouched
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [CNT_W-1:0] data;
  } req_t;

endpackage

// File: rtl/timer_dispatch_fifo.sv
// Small synchronous FIFO holding queued timer requests; flush empties it
// on the same edge and wins over a coincident push.
module sync_fifo
  import timer_dispatch_pkg::*;
#(
  parameter int WIDTH = REQ_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o && !flush_i;
  assign doPop   = pop_i && !empty_o;
  assign rdata_o = mem_q[rdPtr_q];

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/timer_dispatch.sv
// Initiator side of the timer cs/op/data/rdy interface: queues wait requests,
// strobes them to the timer one at a time and reports completion or arm timeout.
module timer_dispatch
  import timer_dispatch_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ARM_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op,
  input  logic [CNT_W-1:0] req_data,
  input  logic             abort,
  output logic             tmr_cs,
  output logic [OP_W-1:0]  tmr_op,
  output logic [CNT_W-1:0] tmr_data,
  input  logic             tmr_rdy,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int ACW = $clog2(ARM_TIMEOUT + 1);
  localparam logic [ACW-1:0] ARM_LAST = ACW'(ARM_TIMEOUT - 1);

  state_e           state_q;
  logic [ACW-1:0]   armCnt_q;
  logic             tmrCs_q;
  logic [OP_W-1:0]  tmrOp_q;
  logic [CNT_W-1:0] tmrData_q;
  logic             done_q;
  logic             err_q;

  req_t             reqIn;
  req_t             head;
  logic [REQ_W-1:0] headRaw;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             pushEn;
  logic             issue_d;

  assign reqIn   = '{op: req_op, data: req_data};
  assign head    = req_t'(headRaw);
  assign pushEn  = req_valid && !fifoFull;
  // Never strobe a timer that is still counting, including one left running across reset
  assign issue_d = (state_q == ST_IDLE) && !fifoEmpty && tmr_rdy;

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pushEn),
    .pop_i   (issue_d),
    .flush_i (abort),
    .wdata_i (reqIn),
    .rdata_o (headRaw),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      armCnt_q  <= '0;
      tmrCs_q   <= 1'b0;
      tmrOp_q   <= '0;
      tmrData_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      tmrCs_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (issue_d) begin
            state_q   <= ST_ISSUE;
            tmrCs_q   <= 1'b1;
            tmrOp_q   <= head.op;
            tmrData_q <= head.data;
          end
        end
        ST_ISSUE: begin
          state_q  <= ST_ARM;
          armCnt_q <= '0;
        end
        ST_ARM: begin
          if (!tmr_rdy) begin
            state_q <= ST_WAIT;
          end else if (armCnt_q == ARM_LAST) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            armCnt_q <= armCnt_q + ACW'(1);
          end
        end
        ST_WAIT: begin
          if (tmr_rdy) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = !fifoFull;
  assign tmr_cs    = tmrCs_q;
  assign tmr_op    = tmrOp_q;
  assign tmr_data  = tmrData_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = !fifoEmpty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_timer_dispatch.sv
// Directed and randomized bench for timer_dispatch with a behavioural timer
// and an issue-order queue as the reference model.
module tb_timer_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [23:0] req_data;
  logic        abort;
  logic        tmr_cs;
  logic [3:0]  tmr_op;
  logic [23:0] tmr_data;
  logic        tmr_rdy = 1'b1;
  logic        done;
  logic        busy;
  logic        err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  timer_dispatch dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .abort     (abort),
    .tmr_cs    (tmr_cs),
    .tmr_op    (tmr_op),
    .tmr_data  (tmr_data),
    .tmr_rdy   (tmr_rdy),
    .done      (done),
    .busy      (busy),
    .err       (err)
  );

  // Behavioural timer: drops rdy the cycle after cs and holds it low for tmr_data cycles
  logic timerDead = 1'b0;
  int   tmrLeft   = 0;
  always @(posedge clk) begin
    if (timerDead) begin
      tmr_rdy <= 1'b1;
    end else if (tmr_cs) begin
      tmr_rdy <= 1'b0;
      tmrLeft <= (tmr_data > 24'd1) ? int'(tmr_data) : 1;
    end else if (!tmr_rdy) begin
      if (tmrLeft <= 1) tmr_rdy <= 1'b1;
      else tmrLeft <= tmrLeft - 1;
    end
  end

  // Observation log: every strobe seen, every done pulse and its timing against rdy
  logic [27:0] csLog[$];
  int   doneCnt  = 0;
  int   doneBad  = 0;
  int   csBad    = 0;
  logic rdyPrev1 = 1'b1;
  logic rdyPrev2 = 1'b1;
  always @(negedge clk) begin
    if (!rst) begin
      if (tmr_cs) begin
        csLog.push_back({tmr_op, tmr_data});
        if (!tmr_rdy) csBad <= csBad + 1;
      end
      if (done) begin
        doneCnt <= doneCnt + 1;
        if (!(rdyPrev1 && !rdyPrev2)) doneBad <= doneBad + 1;
      end
    end
    rdyPrev2 <= rdyPrev1;
    rdyPrev1 <= tmr_rdy;
  end

  logic [27:0] expQ[$];
  int checkedIdx = 0;
  int expDone    = 0;

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  // Offer one request and hold it until accepted; record what the model expects of it
  task automatic applyStimulus(input logic [3:0] op, input logic [23:0] data,
                               input bit expectIssue, input bit expectDone);
    bit accepted = 1'b0;
    int tries = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    while (!accepted && tries < 60) begin
      accepted = req_ready;
      stepCycle();
      tries++;
    end
    req_valid = 1'b0;
    checkOutput("push_accept", 32'(accepted), 32'd1);
    if (expectIssue) expQ.push_back({op, data});
    if (expectDone) expDone++;
  endtask

  task automatic pushOnce(input logic [3:0] op, input logic [23:0] data);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    stepCycle();
    req_valid = 1'b0;
  endtask

  task automatic waitCs(input int target, input string tag);
    int n = 0;
    while (csLog.size() < target && n < 200) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, 32'(csLog.size() >= target), 32'd1);
  endtask

  task automatic waitDoneTotal(input string tag);
    int n = 0;
    while (doneCnt < expDone && n < 400) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, 32'(doneCnt), 32'(expDone));
  endtask

  task automatic waitRdyLow(input string tag);
    int n = 0;
    while (tmr_rdy && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, 32'(tmr_rdy), 32'd0);
  endtask

  task automatic checkIssues(input string tag);
    checkOutput({tag, "_count"}, 32'(csLog.size()), 32'(expQ.size()));
    for (int i = checkedIdx; i < csLog.size() && i < expQ.size(); i++)
      checkOutput({tag, "_entry"}, {4'd0, csLog[i]}, {4'd0, expQ[i]});
    checkedIdx = (csLog.size() > expQ.size()) ? csLog.size() : expQ.size();
  endtask

  initial begin
    int          base;
    int          n;
    logic [3:0]  op;
    logic [23:0] data;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_data  = '0;
    abort     = 1'b0;
    repeat (3) stepCycle();

    $display("[TB] reset state");
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_cs",    32'(tmr_cs),    32'd0);
    checkOutput("rst_done",  32'(done),      32'd0);
    checkOutput("rst_busy",  32'(busy),      32'd0);
    checkOutput("rst_err",   32'(err),       32'd0);
    checkOutput("rst_op",    32'(tmr_op),    32'd0);
    checkOutput("rst_data",  32'(tmr_data),  32'd0);
    rst = 1'b0;
    stepCycle();

    $display("[TB] single request");
    applyStimulus(4'h0, 24'd5, 1'b1, 1'b1);
    waitCs(1, "s1_cs");
    checkOutput("s1_data", 32'(tmr_data), 32'd5);
    waitDoneTotal("s1_done");
    repeat (3) stepCycle();
    checkIssues("s1");
    checkOutput("s1_busy", 32'(busy), 32'd0);

    $display("[TB] fill queue behind a long wait");
    base = csLog.size();
    applyStimulus(4'($urandom), 24'($urandom_range(12, 16)), 1'b1, 1'b1);
    waitCs(base + 1, "s2_cs");
    for (int i = 1; i <= 4; i++) begin
      checkOutput("s2_ready_free", 32'(req_ready), 32'd1);
      op = 4'($urandom);
      pushOnce(op, 24'(i));
      expQ.push_back({op, 24'(i)});
      expDone++;
    end
    checkOutput("s2_ready_full", 32'(req_ready), 32'd0);
    checkOutput("s2_busy_full", 32'(busy), 32'd1);
    pushOnce(4'hF, 24'd9);
    waitDoneTotal("s2_done");
    repeat (3) stepCycle();
    checkIssues("s2");
    checkOutput("s2_busy", 32'(busy), 32'd0);

    $display("[TB] arm timeout");
    timerDead = 1'b1;
    base = csLog.size();
    applyStimulus(4'($urandom), 24'($urandom_range(1, 8)), 1'b1, 1'b0);
    waitCs(base + 1, "s3_cs");
    repeat (8) stepCycle();
    checkOutput("s3_err_early", 32'(err), 32'd0);
    stepCycle();
    checkOutput("s3_err_set", 32'(err), 32'd1);
    checkOutput("s3_busy", 32'(busy), 32'd0);
    repeat (4) stepCycle();
    checkOutput("s3_no_done", 32'(doneCnt), 32'(expDone));
    checkIssues("s3");
    timerDead = 1'b0;

    $display("[TB] abort during wait");
    base = csLog.size();
    applyStimulus(4'($urandom), 24'($urandom_range(3, 6)), 1'b1, 1'b1);
    applyStimulus(4'($urandom), 24'($urandom_range(3, 6)), 1'b0, 1'b0);
    applyStimulus(4'($urandom), 24'($urandom_range(3, 6)), 1'b0, 1'b0);
    waitCs(base + 1, "s4_cs");
    waitRdyLow("s4_armed");
    stepCycle();
    abort = 1'b1;
    stepCycle();
    abort = 1'b0;
    waitDoneTotal("s4_done");
    repeat (10) stepCycle();
    checkIssues("s4");
    checkOutput("s4_busy", 32'(busy), 32'd0);
    checkOutput("s4_err_sticky", 32'(err), 32'd1);

    $display("[TB] reset while waiting");
    base = csLog.size();
    applyStimulus(4'($urandom), 24'd20, 1'b1, 1'b0);
    waitCs(base + 1, "s5_cs");
    waitRdyLow("s5_armed");
    stepCycle();
    rst = 1'b1;
    stepCycle();
    checkOutput("s5_rst_ready", 32'(req_ready), 32'd1);
    checkOutput("s5_rst_busy",  32'(busy),      32'd0);
    checkOutput("s5_rst_err",   32'(err),       32'd0);
    checkOutput("s5_rst_done",  32'(done),      32'd0);
    checkOutput("s5_rst_op",    32'(tmr_op),    32'd0);
    checkOutput("s5_rst_data",  32'(tmr_data),  32'd0);
    rst = 1'b0;
    base = csLog.size();
    applyStimulus(4'($urandom), 24'($urandom_range(1, 8)), 1'b1, 1'b1);
    n = 0;
    while (!tmr_rdy && n < 40) begin
      stepCycle();
      n++;
    end
    checkOutput("s5_rdy_back", 32'(tmr_rdy), 32'd1);
    checkOutput("s5_held", 32'(csLog.size()), 32'(base));
    waitCs(base + 1, "s5_cs_new");
    waitDoneTotal("s5_done");
    repeat (3) stepCycle();
    checkIssues("s5");

    $display("[TB] long op passthrough and push with abort");
    base = csLog.size();
    applyStimulus(4'b1000, 24'h000002, 1'b1, 1'b1);
    waitCs(base + 1, "s6_cs");
    checkOutput("s6_op", 32'(tmr_op), 32'd8);
    checkOutput("s6_data", 32'(tmr_data), 32'd2);
    waitDoneTotal("s6_done");
    repeat (3) stepCycle();
    checkOutput("s6_op_held", 32'(tmr_op), 32'd8);
    checkOutput("s6_data_held", 32'(tmr_data), 32'd2);
    checkIssues("s6");
    base = csLog.size();
    req_valid = 1'b1;
    abort     = 1'b1;
    req_op    = 4'($urandom);
    req_data  = 24'($urandom_range(1, 8));
    stepCycle();
    req_valid = 1'b0;
    abort     = 1'b0;
    repeat (15) stepCycle();
    checkOutput("s6_dropped", 32'(csLog.size()), 32'(base));
    checkOutput("s6_busy", 32'(busy), 32'd0);

    $display("[TB] random request stream");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'($urandom), 24'($urandom_range(1, 8)), 1'b1, 1'b1);
      repeat ($urandom_range(0, 3)) stepCycle();
    end
    waitDoneTotal("s7_done");
    repeat (5) stepCycle();
    checkIssues("s7");
    checkOutput("s7_busy", 32'(busy), 32'd0);

    checkOutput("final_done",   32'(doneCnt), 32'(expDone));
    checkOutput("done_timing",  32'(doneBad), 32'd0);
    checkOutput("cs_while_low", 32'(csBad),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
